code_entry_buffer: RTL and testbench
====================================

Name: code_entry_buffer

Overview:
Parametrised successor to the single-digit entry pulse stage. It accepts debounced digit-entry pulses and assembles up to NUM_DIGITS digits into a shift buffer, with backspace, clear and inactivity timeout. It presents the finished code to the safe controller FSM under a valid/ack handshake. It sits between the debounced key/switch inputs and the comparator/lock FSM, and feeds the Shift & Display Controller.

Parameters:
NUM_DIGITS, 4, number of digits in a complete code (>=2)
DIGIT_W, 4, bits per digit
MAX_DIGIT, 9, largest legal digit value; larger values are rejected
TIMEOUT_CYCLES, 50000000, inactivity cycles before a partial entry is discarded; 0 disables the timeout
AUTO_SUBMIT, 1, 1 = present the code automatically when the Nth digit is stored; 0 = wait for submit_pulse

Ports:
clk  in  1  system clock, rising edge
sys_reset_n  in  1  asynchronous, active-low reset
enable_entry  in  1  1 = entry accepted
digit_in  in  DIGIT_W  digit value, sampled on entry_pulse
entry_pulse  in  1  1-cycle debounced store request
backspace_pulse  in  1  1-cycle: remove the most recent digit
clear_pulse  in  1  1-cycle: discard the whole buffer
submit_pulse  in  1  1-cycle: present the buffer (used when AUTO_SUBMIT=0, also honoured when AUTO_SUBMIT=1)
code_ack  in  1  consumer accepts the presented code
store_digit_pulse  out  1  1-cycle: a digit was accepted (display shift)
reject_pulse  out  1  1-cycle: an entry was refused
timeout_pulse  out  1  1-cycle: buffer discarded by timeout
digit_count  out  CW=$clog2(NUM_DIGITS+1)  digits currently held
code_out  out  NUM_DIGITS*DIGIT_W  buffer; newest digit in bits [DIGIT_W-1:0]
code_valid  out  1  code presented; held until acknowledged

Behaviour:
- Reset (sys_reset_n=0, asynchronous): state IDLE, code_out=0, digit_count=0, timeout counter=0. All pulse outputs and code_valid are 0.
- States and transitions:
  - IDLE: count=0; the first accepted digit moves to ENTRY.
  - ENTRY: 0<count<N.
  - FULL: count=N, only reachable when AUTO_SUBMIT=0.
  - PRESENT: code_valid=1.
- All outputs are registered. store_digit_pulse and reject_pulse assert the cycle after the input pulse.
- Accept rule: an entry is accepted when enable_entry=1, state is IDLE or ENTRY, and digit_in<=MAX_DIGIT.
  - On accept: code_out <= {code_out[(N-1)*W-1:0], digit_in}; count+1.
- Reject rule: an entry_pulse with enable_entry=1 is rejected if digit_in>MAX_DIGIT or state is FULL or PRESENT. A reject sets reject_pulse=1 and leaves the buffer unchanged.
- Backspace (ENTRY or FULL): code_out shifts right by W with zero fill at the top; count-1. Count reaching 0 returns to IDLE. In IDLE, backspace is a no-op.
- Clear (IDLE, ENTRY or FULL): code_out=0, count=0, next state IDLE.
- Priority when several pulses occur in one cycle: clear > backspace > entry > submit. Only the highest-priority pulse acts; the others are dropped without a reject.
- Submit in ENTRY or FULL moves to PRESENT next cycle. Submit in IDLE is ignored. Partial codes are presented with digit_count < N.
- AUTO_SUBMIT=1: the Nth accepted digit moves to PRESENT. code_valid asserts in the same cycle as the final store_digit_pulse.
- PRESENT handshake:
  - code_out and digit_count are frozen while code_valid=1.
  - code_ack is only sampled while code_valid=1. On ack, the next cycle has code_valid=0, code_out=0, count=0, state IDLE.
  - Entry, backspace, clear, submit and timeout are all ignored in PRESENT; entry pulses produce reject_pulse.
- enable_entry=0: in ENTRY or FULL, the buffer clears and the state goes to IDLE next cycle. In PRESENT it has no effect. All pulse inputs are ignored and no reject is generated.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter runs only in ENTRY or FULL and resets to 0 on any accepted entry or backspace.
  - On reaching TIMEOUT_CYCLES-1: buffer cleared, state IDLE, timeout_pulse=1 for one cycle.
  - A clear or backspace arriving in the same cycle wins, and timeout_pulse stays 0.
- Reset asserted mid-operation aborts immediately, including in PRESENT. A code in PRESENT is lost with no ack.

Test Plan:
- Defaults: reset, enable_entry=1, enter 1,2,3,4 -> store_digit_pulse x4; code_out=16'h1234, digit_count=4, code_valid=1 with the 4th store pulse; code_ack -> next cycle code_valid=0, code_out=0.
- Enter 7,8, backspace, enter 5 -> code_out=16'h0075, count=2; clear -> code_out=0, count=0, IDLE; a further backspace is a no-op.
- Digit_in=4'hA on entry_pulse -> reject_pulse=1 one cycle later; buffer and count unchanged. In PRESENT with ack withheld 20 cycles, entries give reject_pulse and code_out stays frozen.
- AUTO_SUBMIT=0: enter 4 digits -> FULL, code_valid=0; a 5th entry -> reject; submit_pulse -> code_valid=1. Also submit after 2 digits -> code_valid=1, digit_count=2.
- TIMEOUT_CYCLES=16: one digit, then idle -> timeout_pulse exactly 16 cycles after the accepted digit, buffer cleared. Repeat with backspace/entry at cycle 10 -> counter restarts, no early timeout.
- Entry, backspace and clear in the same cycle -> only clear acts. sys_reset_n pulsed low mid-entry between clock edges -> outputs zero immediately (asynchronous).

Source files
------------

// File: rtl/code_entry_if.sv
`default_nettype none
// ============================================================================
//  Module   : code_entry_if
//  Purpose  : Handshake/bus bundle between the key-entry front end and the
//             code_entry_buffer. The slave modport is the buffer's view; the
//             master modport is the producer/consumer side.
//  Signals  : enable_entry, digit_in, entry/backspace/clear/submit pulses,
//             code_ack (master -> slave); store_digit_pulse, reject_pulse,
//             timeout_pulse, digit_count, code_out, code_valid (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface code_entry_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  localparam int CW     = $clog2(NUM_DIGITS + 1);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;

  logic               enable_entry;
  logic [DIGIT_W-1:0] digit_in;
  logic               entry_pulse;
  logic               backspace_pulse;
  logic               clear_pulse;
  logic               submit_pulse;
  logic               code_ack;
  logic               store_digit_pulse;
  logic               reject_pulse;
  logic               timeout_pulse;
  logic [CW-1:0]      digit_count;
  logic [CODE_W-1:0]  code_out;
  logic               code_valid;

  modport slave (
    input  enable_entry, digit_in, entry_pulse, backspace_pulse,
           clear_pulse, submit_pulse, code_ack,
    output store_digit_pulse, reject_pulse, timeout_pulse,
           digit_count, code_out, code_valid
  );

  modport master (
    output enable_entry, digit_in, entry_pulse, backspace_pulse,
           clear_pulse, submit_pulse, code_ack,
    input  store_digit_pulse, reject_pulse, timeout_pulse,
           digit_count, code_out, code_valid
  );
endinterface
`default_nettype wire

// File: rtl/code_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : code_entry_buffer
//  Purpose  : Assembles up to NUM_DIGITS debounced digit entries into a shift
//             buffer (newest digit in the low bits) with backspace, clear and
//             inactivity timeout, then presents the code under valid/ack.
//  Ports    : clk          - system clock, rising edge
//             sys_reset_n  - asynchronous active-low reset
//             bus          - code_entry_if.slave (entry inputs, code outputs)
//  Revision : 1.0  initial release
// ============================================================================
module code_entry_buffer #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_DIGIT      = 9,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int AUTO_SUBMIT    = 1
) (
  input  wire         clk,
  input  wire         sys_reset_n,
  code_entry_if.slave bus
);
  localparam int CW     = $clog2(NUM_DIGITS + 1);
  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DIGIT_W-1:0] c_MAX_DIGIT = DIGIT_W'(MAX_DIGIT);
  localparam logic [CW-1:0]      c_N         = CW'(NUM_DIGITS);
  localparam logic [CW-1:0]      c_ONE       = CW'(1);
  localparam logic [TW-1:0]      c_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic               c_TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic               c_AUTO      = (AUTO_SUBMIT != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_FULL    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CODE_W-1:0]   r_code,  w_code_nxt;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic                r_store, w_store_nxt;
  logic                r_reject, w_reject_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                r_valid, w_valid_nxt;
  logic                w_active;

  // A partial or complete (not yet presented) code is being held.
  assign w_active = (r_state == S_ENTRY) || (r_state == S_FULL);

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_count   <= '0;
      r_timer   <= '0;
      r_store   <= 1'b0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_count   <= w_count_nxt;
      r_timer   <= w_timer_nxt;
      r_store   <= w_store_nxt;
      r_reject  <= w_reject_nxt;
      r_timeout <= w_timeout_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_count_nxt   = r_count;
    w_timer_nxt   = r_timer;
    w_store_nxt   = 1'b0;
    w_reject_nxt  = 1'b0;
    w_timeout_nxt = 1'b0;
    w_valid_nxt   = r_valid;

    if (r_state == S_PRESENT) begin
      // Buffer is frozen; only the acknowledge can release it.
      if (r_valid && bus.code_ack) begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = '0;
        w_count_nxt = '0;
        w_valid_nxt = 1'b0;
      end else if (bus.enable_entry && bus.entry_pulse) begin
        w_reject_nxt = 1'b1;
      end
    end else if (!bus.enable_entry) begin
      // Disabling entry abandons any partial code.
      w_state_nxt = S_IDLE;
      w_code_nxt  = '0;
      w_count_nxt = '0;
      w_timer_nxt = '0;
    end else if (bus.clear_pulse) begin
      w_state_nxt = S_IDLE;
      w_code_nxt  = '0;
      w_count_nxt = '0;
      w_timer_nxt = '0;
    end else if (bus.backspace_pulse) begin
      // Backspace outranks entry even in IDLE, where it does nothing.
      if (w_active) begin
        w_code_nxt  = {{DIGIT_W{1'b0}}, r_code[CODE_W-1:DIGIT_W]};
        w_count_nxt = r_count - c_ONE;
        w_timer_nxt = '0;
        w_state_nxt = (r_count == c_ONE) ? S_IDLE : S_ENTRY;
      end
    end else if (bus.entry_pulse) begin
      if ((r_state == S_FULL) || (bus.digit_in > c_MAX_DIGIT)) begin
        w_reject_nxt = 1'b1;
      end else begin
        w_code_nxt  = {r_code[CODE_W-DIGIT_W-1:0], bus.digit_in};
        w_count_nxt = r_count + c_ONE;
        w_timer_nxt = '0;
        w_store_nxt = 1'b1;
        if ((r_count + c_ONE) == c_N) begin
          if (c_AUTO) begin
            w_state_nxt = S_PRESENT;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_FULL;
          end
        end else begin
          w_state_nxt = S_ENTRY;
        end
      end
    end else if (bus.submit_pulse && w_active) begin
      w_state_nxt = S_PRESENT;
      w_valid_nxt = 1'b1;
      w_timer_nxt = '0;
    end else if (c_TO_EN && w_active) begin
      if (r_timer == c_TO_LAST) begin
        w_state_nxt   = S_IDLE;
        w_code_nxt    = '0;
        w_count_nxt   = '0;
        w_timer_nxt   = '0;
        w_timeout_nxt = 1'b1;
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
    end
  end

  assign bus.store_digit_pulse = r_store;
  assign bus.reject_pulse      = r_reject;
  assign bus.timeout_pulse     = r_timeout;
  assign bus.digit_count       = r_count;
  assign bus.code_out          = r_code;
  assign bus.code_valid        = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_code_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_code_entry_buffer
//  Purpose  : Bench for code_entry_buffer. Instance A: auto-submit with a
//             16-cycle timeout. Instance B: manual submit, timeout disabled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_code_entry_buffer;

  typedef struct {
    logic        en;
    logic [3:0]  dig;
    logic        ent, bs, clr, sub, ack;
    logic        st, rj, to;
    logic [2:0]  cnt;
    logic [15:0] code;
    logic        val;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  code_entry_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus_a ();
  code_entry_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus_b ();

  code_entry_buffer #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9),
                      .TIMEOUT_CYCLES(16), .AUTO_SUBMIT(1)) u_a (
    .clk(clk), .sys_reset_n(rst_n), .bus(bus_a));

  code_entry_buffer #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9),
                      .TIMEOUT_CYCLES(0), .AUTO_SUBMIT(0)) u_b (
    .clk(clk), .sys_reset_n(rst_n), .bus(bus_b));

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  function automatic vec_t v(input logic en, input logic [3:0] dig,
                             input logic ent, input logic bs, input logic clr,
                             input logic sub, input logic ack,
                             input logic st, input logic rj, input logic to,
                             input logic [2:0] cnt, input logic [15:0] code,
                             input logic val, input string name);
    vec_t t;
    t.en = en; t.dig = dig; t.ent = ent; t.bs = bs; t.clr = clr;
    t.sub = sub; t.ack = ack; t.st = st; t.rj = rj; t.to = to;
    t.cnt = cnt; t.code = code; t.val = val; t.name = name;
    return t;
  endfunction

  function automatic vec_t idle(input logic [2:0] cnt, input logic [15:0] code,
                                input logic val, input logic to, input string name);
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, to, cnt, code, val, name);
  endfunction

  task automatic drive(input int k, input vec_t t);
    if (k == 0) begin
      bus_a.enable_entry = t.en;  bus_a.digit_in = t.dig;
      bus_a.entry_pulse = t.ent;  bus_a.backspace_pulse = t.bs;
      bus_a.clear_pulse = t.clr;  bus_a.submit_pulse = t.sub;
      bus_a.code_ack = t.ack;
      bus_b.entry_pulse = 0; bus_b.backspace_pulse = 0; bus_b.clear_pulse = 0;
      bus_b.submit_pulse = 0; bus_b.code_ack = 0;
    end else begin
      bus_b.enable_entry = t.en;  bus_b.digit_in = t.dig;
      bus_b.entry_pulse = t.ent;  bus_b.backspace_pulse = t.bs;
      bus_b.clear_pulse = t.clr;  bus_b.submit_pulse = t.sub;
      bus_b.code_ack = t.ack;
      bus_a.entry_pulse = 0; bus_a.backspace_pulse = 0; bus_a.clear_pulse = 0;
      bus_a.submit_pulse = 0; bus_a.code_ack = 0;
    end
  endtask

  task automatic compare(input int k, input vec_t e);
    logic st, rj, to, val;
    logic [2:0] cnt;
    logic [15:0] code;
    if (k == 0) begin
      st = bus_a.store_digit_pulse; rj = bus_a.reject_pulse; to = bus_a.timeout_pulse;
      cnt = bus_a.digit_count; code = bus_a.code_out; val = bus_a.code_valid;
    end else begin
      st = bus_b.store_digit_pulse; rj = bus_b.reject_pulse; to = bus_b.timeout_pulse;
      cnt = bus_b.digit_count; code = bus_b.code_out; val = bus_b.code_valid;
    end
    n_tests++;
    if (st !== e.st || rj !== e.rj || to !== e.to || cnt !== e.cnt ||
        code !== e.code || val !== e.val) begin
      n_fail++;
      $display("FAIL %s[%0d]: got st=%b rj=%b to=%b cnt=%0d code=%h valid=%b, want st=%b rj=%b to=%b cnt=%0d code=%h valid=%b",
               e.name, k, st, rj, to, cnt, code, val,
               e.st, e.rj, e.to, e.cnt, e.code, e.val);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check the
  // registered response just after the capturing edge.
  task automatic apply(input int k, input vec_t t);
    vec_t e;
    @(negedge clk);
    drive(k, t);
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(k, e);
  endtask

  // One digit (or two when `two` is set), optional restart event at idle
  // cycle 10, then the timeout must land exactly 16 cycles after the last
  // counter restart.
  task automatic timeout_seq(input int restart, input string name);
    logic [2:0]  cnt;
    logic [15:0] code;
    if (restart == 2) begin
      apply(0, v(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0005, 0, {name, "_d0"}));
      apply(0, v(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0056, 0, {name, "_d1"}));
      cnt = 2; code = 16'h0056;
    end else begin
      apply(0, v(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0005, 0, {name, "_d0"}));
      cnt = 1; code = 16'h0005;
    end
    if (restart != 0) begin
      for (int i = 1; i < 10; i++) apply(0, idle(cnt, code, 0, 0, {name, "_pre"}));
      if (restart == 1) begin
        apply(0, v(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0056, 0, {name, "_ent10"}));
        cnt = 2; code = 16'h0056;
      end else begin
        apply(0, v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0005, 0, {name, "_bs10"}));
        cnt = 1; code = 16'h0005;
      end
    end
    for (int i = 1; i < 16; i++) apply(0, idle(cnt, code, 0, 0, {name, "_wait"}));
    apply(0, idle(0, 16'h0000, 0, 1, {name, "_fire"}));
    apply(0, idle(0, 16'h0000, 0, 0, {name, "_after"}));
  endtask

  initial begin
    drive(0, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "init"));
    drive(1, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "init"));

    // Instance A: auto-submit
    tbl_a.push_back(idle(0, 16'h0000, 0, 0, "reset_state"));
    tbl_a.push_back(v(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0001, 0, "d1"));
    tbl_a.push_back(v(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0012, 0, "d2"));
    tbl_a.push_back(v(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 3, 16'h0123, 0, "d3"));
    tbl_a.push_back(v(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 4, 16'h1234, 1, "d4_valid"));
    tbl_a.push_back(idle(4, 16'h1234, 1, 0, "hold"));
    tbl_a.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, "ack"));
    tbl_a.push_back(v(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0007, 0, "d7"));
    tbl_a.push_back(v(1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0078, 0, "d8"));
    tbl_a.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0007, 0, "bksp"));
    tbl_a.push_back(v(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0075, 0, "d5"));
    tbl_a.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, "clear"));
    tbl_a.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, "bksp_idle"));
    tbl_a.push_back(v(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0003, 0, "d3b"));
    tbl_a.push_back(v(1, 4'hA, 1, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0003, 0, "reject_A"));
    tbl_a.push_back(v(1, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, "prio_clear"));
    tbl_a.push_back(v(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0001, 0, "en_d1"));
    tbl_a.push_back(v(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, "disable"));
    tbl_a.push_back(v(0, 4'hB, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, "dis_noreject"));
    tbl_a.push_back(v(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0009, 0, "d9"));
    tbl_a.push_back(v(1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0098, 0, "d8b"));
    tbl_a.push_back(v(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 3, 16'h0987, 0, "d7b"));
    tbl_a.push_back(v(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 4, 16'h9876, 1, "d6_valid"));
    for (int i = 0; i < 20; i++)
      tbl_a.push_back(v(1, 5, (i % 2) == 0, i == 3, i == 7, i == 11, 0,
                        0, (i % 2) == 0, 0, 4, 16'h9876, 1, "present_frozen"));
    tbl_a.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, "ack2"));

    // Instance B: manual submit
    tbl_b.push_back(idle(0, 16'h0000, 0, 0, "b_reset_state"));
    tbl_b.push_back(v(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0001, 0, "b_d1"));
    tbl_b.push_back(v(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0012, 0, "b_d2"));
    tbl_b.push_back(v(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 3, 16'h0123, 0, "b_d3"));
    tbl_b.push_back(v(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 4, 16'h1234, 0, "b_full"));
    tbl_b.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 4, 16'h1234, 0, "b_5th_reject"));
    tbl_b.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 16'h0123, 0, "b_bksp_full"));
    tbl_b.push_back(v(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 4, 16'h1234, 0, "b_refill"));
    tbl_b.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 16'h1234, 1, "b_submit"));
    tbl_b.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, "b_ack"));
    tbl_b.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, "b_submit_idle"));
    tbl_b.push_back(v(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0001, 0, "b_p1"));
    tbl_b.push_back(v(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 2, 16'h0012, 0, "b_p2"));
    tbl_b.push_back(v(1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 2, 16'h0012, 1, "b_partial"));
    tbl_b.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 16'h0012, 1, "b_clr_ignored"));
    tbl_b.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0012, 1, "b_dis_present"));
    tbl_b.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, "b_ack2"));

    repeat (3) @(posedge clk);
    #1;
    compare(0, idle(0, 16'h0000, 0, 0, "in_reset"));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl_a[i]) apply(0, tbl_a[i]);
    foreach (tbl_b[i]) apply(1, tbl_b[i]);

    timeout_seq(0, "to_plain");
    timeout_seq(1, "to_ent_restart");
    timeout_seq(2, "to_bs_restart");

    // Asynchronous reset between clock edges while a digit is held.
    apply(0, v(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0007, 0, "pre_reset"));
    apply(1, v(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0007, 0, "b_pre_reset"));
    #2;
    rst_n = 1'b0;
    #1;
    compare(0, idle(0, 16'h0000, 0, 0, "async_reset"));
    compare(1, idle(0, 16'h0000, 0, 0, "b_async_reset"));
    @(negedge clk);
    drive(0, idle(0, 0, 0, 0, "rel"));
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, idle(0, 16'h0000, 0, 0, "post_reset"));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
